// File: rtl/cva6_obi_mux_pkg.sv
// Shared types and constants for the CVA6 OBI manager multiplexer.
package cva6_obi_mux_pkg;

  localparam int NUM_MGR   = 6;
  localparam int MGR_IDX_W = $clog2(NUM_MGR);

  typedef logic [MGR_IDX_W-1:0] mgr_idx_t;

  localparam mgr_idx_t FETCH   = mgr_idx_t'(0);
  localparam mgr_idx_t STORE   = mgr_idx_t'(1);
  localparam mgr_idx_t LOAD    = mgr_idx_t'(2);
  localparam mgr_idx_t AMO     = mgr_idx_t'(3);
  localparam mgr_idx_t MMU_PTW = mgr_idx_t'(4);
  localparam mgr_idx_t ZCMT    = mgr_idx_t'(5);

  function automatic mgr_idx_t wrap_inc(mgr_idx_t idx, int n);
    return (idx == mgr_idx_t'(n - 1)) ? '0 : idx + mgr_idx_t'(1);
  endfunction

endpackage

// File: rtl/cva6_obi_id_fifo.sv
// In-order FIFO of manager indices used to route OBI responses back.
module cva6_obi_id_fifo
  import cva6_obi_mux_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  mgr_idx_t data_i,
  input  logic     pop_i,
  output mgr_idx_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PtrW = $clog2(Depth);

  mgr_idx_t        mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count == (PtrW+1)'(Depth));
  assign empty_o = (count == '0);
  assign data_o  = mem[rd_ptr];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cva6_obi_mux.sv
// Merges the CVA6 OBI manager ports onto one subordinate port with a
// lock-preserving round-robin arbiter and in-order response routing.
module cva6_obi_mux
  import cva6_obi_mux_pkg::*;
#(
  parameter int NumMgr         = NUM_MGR,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumMgr-1:0]                     mgr_req_i,
  output logic [NumMgr-1:0]                     mgr_gnt_o,
  input  logic [NumMgr-1:0][AddrWidth-1:0]      mgr_addr_i,
  input  logic [NumMgr-1:0]                     mgr_we_i,
  input  logic [NumMgr-1:0][DataWidth/8-1:0]    mgr_be_i,
  input  logic [NumMgr-1:0][DataWidth-1:0]      mgr_wdata_i,
  output logic [NumMgr-1:0]                     mgr_rvalid_o,
  output logic [DataWidth-1:0]                  mgr_rdata_o,
  output logic                                  mgr_err_o,
  output logic                                  sbr_req_o,
  input  logic                                  sbr_gnt_i,
  output logic [AddrWidth-1:0]                  sbr_addr_o,
  output logic                                  sbr_we_o,
  output logic [DataWidth/8-1:0]                sbr_be_o,
  output logic [DataWidth-1:0]                  sbr_wdata_o,
  input  logic                                  sbr_rvalid_i,
  input  logic [DataWidth-1:0]                  sbr_rdata_i,
  input  logic                                  sbr_err_i,
  output logic                                  protocol_err_o
);

  logic            any_req;
  logic            fwd;
  logic            grant;
  logic            resp_ok;
  logic            fifo_full;
  logic            fifo_empty;
  mgr_idx_t        fifo_head;
  mgr_idx_t        rr;
  mgr_idx_t        rr_pick;
  mgr_idx_t        sel;
  mgr_idx_t        lock_idx;
  logic            lock_vld;
  logic [NumMgr-1:0]    req_rot;
  logic [MGR_IDX_W:0]   pick_sum;

  // Rotate requests so bit 0 is the manager at rr; the lowest set bit wins.
  always_comb begin
    req_rot  = NumMgr'({mgr_req_i, mgr_req_i} >> rr);
    pick_sum = {1'b0, rr};
    for (int i = NumMgr - 1; i >= 0; i--) begin
      if (req_rot[i]) pick_sum = {1'b0, rr} + (MGR_IDX_W+1)'(i);
    end
    if (pick_sum >= (MGR_IDX_W+1)'(NumMgr)) pick_sum = pick_sum - (MGR_IDX_W+1)'(NumMgr);
    rr_pick = pick_sum[MGR_IDX_W-1:0];
  end

  assign any_req   = |mgr_req_i;
  assign fwd       = rst_ni & any_req;
  assign sel       = lock_vld ? lock_idx : rr_pick;
  assign sbr_req_o = fwd & ~fifo_full;
  assign grant     = sbr_req_o & sbr_gnt_i;
  assign resp_ok   = rst_ni & sbr_rvalid_i & ~fifo_empty;

  assign sbr_addr_o  = fwd ? mgr_addr_i[sel]  : '0;
  assign sbr_we_o    = fwd ? mgr_we_i[sel]    : 1'b0;
  assign sbr_be_o    = fwd ? mgr_be_i[sel]    : '0;
  assign sbr_wdata_o = fwd ? mgr_wdata_i[sel] : '0;

  assign mgr_rdata_o = rst_ni ? sbr_rdata_i : '0;
  assign mgr_err_o   = rst_ni & sbr_err_i;

  always_comb begin
    mgr_gnt_o    = '0;
    mgr_rvalid_o = '0;
    if (grant)   mgr_gnt_o[sel]          = 1'b1;
    if (resp_ok) mgr_rvalid_o[fifo_head] = 1'b1;
  end

  cva6_obi_id_fifo #(
    .Depth (MaxOutstanding)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (resp_ok),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // An ungranted request pins sel so address-phase fields stay stable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr             <= '0;
      lock_vld       <= 1'b0;
      lock_idx       <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (grant) begin
        rr       <= wrap_inc(sel, NumMgr);
        lock_vld <= 1'b0;
      end else if (sbr_req_o) begin
        lock_vld <= 1'b1;
        lock_idx <= sel;
      end
      if (sbr_rvalid_i && fifo_empty) protocol_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cva6_obi_mux.sv
// Randomized and directed bench for cva6_obi_mux with a queue-based reference model.
module tb_cva6_obi_mux;

  localparam int N     = 6;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N-1:0]            mgr_req;
  logic [N-1:0]            mgr_gnt;
  logic [N-1:0][AW-1:0]    mgr_addr;
  logic [N-1:0]            mgr_we;
  logic [N-1:0][BW-1:0]    mgr_be;
  logic [N-1:0][DW-1:0]    mgr_wdata;
  logic [N-1:0]            mgr_rvalid;
  logic [DW-1:0]           mgr_rdata;
  logic                    mgr_err;
  logic                    sbr_req;
  logic                    sbr_gnt;
  logic [AW-1:0]           sbr_addr;
  logic                    sbr_we;
  logic [BW-1:0]           sbr_be;
  logic [DW-1:0]           sbr_wdata;
  logic                    sbr_rvalid;
  logic [DW-1:0]           sbr_rdata;
  logic                    sbr_err;
  logic                    perr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: issued-manager queue, round-robin start, held index.
  int           q[$];
  int           rr_m = 0;
  bit           held_v = 1'b0;
  int           held_i = 0;
  bit           perr_m = 1'b0;
  logic [N-1:0] gnt_last = '0;

  always #5 clk = ~clk;

  cva6_obi_mux #(
    .NumMgr         (N),
    .AddrWidth      (AW),
    .DataWidth      (DW),
    .MaxOutstanding (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mgr_req_i      (mgr_req),
    .mgr_gnt_o      (mgr_gnt),
    .mgr_addr_i     (mgr_addr),
    .mgr_we_i       (mgr_we),
    .mgr_be_i       (mgr_be),
    .mgr_wdata_i    (mgr_wdata),
    .mgr_rvalid_o   (mgr_rvalid),
    .mgr_rdata_o    (mgr_rdata),
    .mgr_err_o      (mgr_err),
    .sbr_req_o      (sbr_req),
    .sbr_gnt_i      (sbr_gnt),
    .sbr_addr_o     (sbr_addr),
    .sbr_we_o       (sbr_we),
    .sbr_be_o       (sbr_be),
    .sbr_wdata_o    (sbr_wdata),
    .sbr_rvalid_i   (sbr_rvalid),
    .sbr_rdata_i    (sbr_rdata),
    .sbr_err_i      (sbr_err),
    .protocol_err_o (perr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every cycle against the model, then advance the model.
  always @(negedge clk) begin : monitor
    int           sel;
    bit           exp_req;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
    chk("protocol_err", 64'(perr), 64'(perr_m));
    if (!rst_n) begin
      chk("rst_sbr_req", 64'(sbr_req), 0);
      chk("rst_mgr_gnt", 64'(mgr_gnt), 0);
      chk("rst_mgr_rvalid", 64'(mgr_rvalid), 0);
      q.delete();
      rr_m     = 0;
      held_v   = 1'b0;
      perr_m   = 1'b0;
      gnt_last = '0;
    end else begin
      sel = rr_m;
      if (held_v) sel = held_i;
      else begin
        for (int k = 0; k < N; k++) begin
          if (mgr_req[(rr_m + k) % N]) begin
            sel = (rr_m + k) % N;
            break;
          end
        end
      end
      exp_req = (mgr_req != '0) && (q.size() < DEPTH);
      exp_gnt = '0;
      if (exp_req && sbr_gnt) exp_gnt[sel] = 1'b1;
      chk("sbr_req", 64'(sbr_req), 64'(exp_req));
      chk("mgr_gnt", 64'(mgr_gnt), 64'(exp_gnt));
      if (exp_req) begin
        chk("sbr_addr", 64'(sbr_addr), 64'(mgr_addr[sel]));
        chk("sbr_we", 64'(sbr_we), 64'(mgr_we[sel]));
        chk("sbr_be", 64'(sbr_be), 64'(mgr_be[sel]));
        chk("sbr_wdata", 64'(sbr_wdata), 64'(mgr_wdata[sel]));
      end
      exp_rv = '0;
      if (sbr_rvalid && q.size() > 0) exp_rv[q[0]] = 1'b1;
      chk("mgr_rvalid", 64'(mgr_rvalid), 64'(exp_rv));
      if (sbr_rvalid && q.size() > 0) begin
        chk("mgr_rdata", 64'(mgr_rdata), 64'(sbr_rdata));
        chk("mgr_err", 64'(mgr_err), 64'(sbr_err));
        void'(q.pop_front());
      end else if (sbr_rvalid) begin
        perr_m = 1'b1;
      end
      if (exp_gnt != '0) begin
        q.push_back(sel);
        rr_m   = (sel + 1) % N;
        held_v = 1'b0;
      end else if (exp_req) begin
        held_v = 1'b1;
        held_i = sel;
      end
      gnt_last = exp_gnt;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mgr_req    = '0;
    sbr_gnt    = 1'b0;
    sbr_rvalid = 1'b0;
    sbr_rdata  = '0;
    sbr_err    = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] pend;
    int           order [3];
    order = '{0, 1, 3};
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < N; i++) begin
      mgr_addr[i]  = 32'h1000_0000 + 32'(i) * 32'h100;
      mgr_we[i]    = 1'(i);
      mgr_be[i]    = 4'hF;
      mgr_wdata[i] = 32'hA500_0000 + 32'(i);
    end
    do_reset();

    // Single load on manager 2 with immediate grant, response 3 cycles later.
    mgr_addr[2] = 32'h8000_0000;
    mgr_req = 6'b000100;
    sbr_gnt = 1'b1;
    #3;
    chk("t1_gnt", 64'(mgr_gnt), 64'(6'b000100));
    chk("t1_addr", 64'(sbr_addr), 64'h8000_0000);
    cyc();
    idle();
    cyc();
    cyc();
    sbr_rvalid = 1'b1;
    sbr_rdata  = 32'hDEAD_BEEF;
    #3;
    chk("t1_rvalid", 64'(mgr_rvalid), 64'(6'b000100));
    chk("t1_rdata", 64'(mgr_rdata), 64'hDEAD_BEEF);
    cyc();
    idle();

    // Managers 0, 1, 3 request continuously with grant held high.
    do_reset();
    mgr_req = 6'b001011;
    sbr_gnt = 1'b1;
    for (int c = 0; c < 9; c++) begin
      sbr_rvalid = (c > 0);
      sbr_rdata  = 32'h0000_C000 + 32'(c);
      #3;
      chk("t2_order", 64'(mgr_gnt), 64'(1) << order[c % 3]);
      cyc();
    end
    idle();
    sbr_rvalid = 1'b1;
    cyc();
    idle();

    // Manager 4 held without grant while manager 0 also requests.
    do_reset();
    mgr_req = 6'b010000;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) mgr_req = 6'b010001;
      #3;
      chk("t3_addr", 64'(sbr_addr), 64'(mgr_addr[4]));
      cyc();
    end
    sbr_gnt = 1'b1;
    #3;
    chk("t3_gnt4", 64'(mgr_gnt), 64'(6'b010000));
    cyc();
    mgr_req = 6'b000001;
    #3;
    chk("t3_gnt0", 64'(mgr_gnt), 64'(6'b000001));
    cyc();
    idle();
    sbr_rvalid = 1'b1;
    cyc();
    cyc();
    idle();

    // Fill the routing FIFO, then release one slot.
    do_reset();
    mgr_req = 6'b000010;
    sbr_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #3;
      chk("t4_gnt", 64'(mgr_gnt), 64'(6'b000010));
      cyc();
    end
    sbr_rvalid = 1'b1;
    #3;
    chk("t4_full_req", 64'(sbr_req), 0);
    cyc();
    sbr_rvalid = 1'b0;
    #3;
    chk("t4_req_back", 64'(sbr_req), 1);
    cyc();
    idle();
    sbr_rvalid = 1'b1;
    for (int c = 0; c < 4; c++) cyc();
    idle();

    // Response with nothing outstanding, then a one-cycle reset.
    do_reset();
    sbr_rvalid = 1'b1;
    sbr_rdata  = 32'h1234_5678;
    #3;
    chk("t5_no_rvalid", 64'(mgr_rvalid), 0);
    cyc();
    idle();
    #3;
    chk("t5_perr_set", 64'(perr), 1);
    cyc();
    cyc();
    #3;
    chk("t5_perr_sticky", 64'(perr), 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #3;
    chk("t5_perr_clr", 64'(perr), 0);
    chk("t5_req", 64'(sbr_req), 0);
    chk("t5_gnt", 64'(mgr_gnt), 0);
    chk("t5_rvalid", 64'(mgr_rvalid), 0);
    chk("t5_addr", 64'(sbr_addr), 0);
    chk("t5_wdata", 64'({sbr_we, sbr_be, sbr_wdata}), 0);

    // Reset with three outstanding requests clears routing state and rr.
    do_reset();
    mgr_req = 6'b001110;
    sbr_gnt = 1'b1;
    for (int c = 0; c < 3; c++) cyc();
    rst_n = 1'b0;
    idle();
    cyc();
    rst_n = 1'b1;
    sbr_rvalid = 1'b1;
    #3;
    chk("t6_fifo_empty", 64'(mgr_rvalid), 0);
    cyc();
    idle();
    mgr_req = 6'b010100;
    sbr_gnt = 1'b1;
    #3;
    chk("t6_gnt_low", 64'(mgr_gnt), 64'(6'b000100));
    cyc();
    idle();
    sbr_rvalid = 1'b1;
    cyc();
    idle();

    // Random traffic with OBI-compliant managers and an in-order subordinate.
    do_reset();
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (gnt_last[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i]      = 1'b1;
          mgr_addr[i]  = $urandom;
          mgr_we[i]    = 1'($urandom);
          mgr_be[i]    = BW'($urandom);
          mgr_wdata[i] = $urandom;
        end
      end
      mgr_req    = pend;
      sbr_gnt    = ($urandom_range(0, 2) != 0);
      sbr_rvalid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      sbr_rdata  = $urandom;
      sbr_err    = 1'($urandom);
      cyc();
    end
    idle();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
